// File: rtl/gps_pkg.sv
// Shared definitions for the GPS-to-MCU sample link: nibble layout, SPI framing, FSM states.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package gps_pkg;

  // Bit positions of the I/Q components inside one 4-bit sample
  localparam int I1 = 3;
  localparam int I0 = 2;
  localparam int Q1 = 1;
  localparam int Q0 = 0;

  // Serial word length on the link
  localparam int SPI_BITS  = 8;
  localparam int BIT_CNT_W = $clog2(SPI_BITS);

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  // Extract one sample from a received byte; the upper nibble is the older sample.
  function automatic nibble_t pick_nibble(input logic [7:0] b, input logic upper);
    logic [7:0] s;
    nibble_t    n;
    s     = upper ? b : (b << 4);
    n[I1] = s[7];
    n[I0] = s[6];
    n[Q1] = s[5];
    n[Q0] = s[4];
    return n;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Generic synchronous FIFO with a registered head word.
// Latency: a push into an empty FIFO is visible on head_dat/!empty the next cycle.
// Backpressure: push is accepted when not full or when a pop happens in the same cycle; otherwise ignored.
module sample_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count;
  logic [AW:0]      count_after_pop;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] head_q;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  assign do_pop          = pop && !empty;
  assign do_push         = push && (!full || do_pop);
  assign count_after_pop = count - (AW+1)'(do_pop);
  assign rd_next         = rd_ptr + AW'(do_pop);

  assign head_dat = head_q;

  // Storage array: written at the tail on every accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_next;
      count  <= count_after_pop + (AW+1)'(do_push);
    end
  end

  // Registered head: bypass the pushed word when it becomes the head, else follow the read pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
    end else if (do_push && (count_after_pop == '0)) begin
      head_q <= push_dat;
    end else if (do_pop && (count_after_pop != '0)) begin
      head_q <= mem[rd_next];
    end
  end

endmodule

// File: rtl/spi_sample_rx.sv
// SPI mode-0 slave deframer: oversamples SCK/SS/MOSI, unpacks each byte into two 4-bit I/Q samples.
// Latency: byte completes at detect cycle E; first sample valid at E+2, second queued at end of E+2.
// Backpressure: valid/ready on the sample FIFO; a nibble that finds the FIFO full is dropped and OVERRUN set.
module spi_sample_rx
  import gps_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        MCU_CLK_25_000,
  input  logic        RESET_N,
  input  logic        MCU_SCK,
  input  logic        MCU_SS,
  input  logic        MCU_MOSI,
  output logic [3:0]  SAMPLE_OUT,
  output logic        SAMPLE_VALID,
  input  logic        SAMPLE_READY,
  output logic [15:0] BYTE_COUNT,
  output logic        FRAME_ERR,
  output logic        OVERRUN
);

  logic clk;
  assign clk = MCU_CLK_25_000;

  // ---------------------------------------------------------------- reset
  logic [1:0] rst_pipe;
  logic       rst_n;

  // Assert immediately, release two clocks after RESET_N rises
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_pipe <= '0;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n = rst_pipe[1];

  // ---------------------------------------------------------- synchronizers
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_hist;
  logic                   ss_hist;
  logic                   sck_s;
  logic                   ss_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   ss_rise;
  logic                   ss_fall;

  // SS resets low in both sync and history so a select already held low at release gives no falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_hist  <= 1'b0;
      ss_hist   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], MCU_SCK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], MCU_SS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MCU_MOSI};
      sck_hist  <= sck_s;
      ss_hist   <= ss_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s && !sck_hist;
  assign ss_rise  = ss_s && !ss_hist;
  assign ss_fall  = !ss_s && ss_hist;

  // -------------------------------------------------------------------- FSM
  spi_state_t           state_q;
  spi_state_t           state_d;
  logic [BIT_CNT_W-1:0] bitcnt;
  logic                 shift_en;
  logic                 byte_done;
  logic                 frame_abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a select falling edge opens a frame, a rising edge closes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = SHIFT;
      SHIFT:   if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoded strobes; a select rising edge wins over a coincident SCK edge
  always_comb begin
    shift_en    = 1'b0;
    byte_done   = 1'b0;
    frame_abort = 1'b0;
    if (state_q == SHIFT) begin
      shift_en    = sck_rise && !ss_rise;
      byte_done   = shift_en && (bitcnt == BIT_CNT_W'(SPI_BITS - 1));
      frame_abort = ss_rise && (bitcnt != '0);
    end
  end

  // --------------------------------------------------------------- datapath
  logic [SPI_BITS-2:0] shreg;
  logic [SPI_BITS-1:0] byte_hold;
  logic [1:0]          pend;
  logic [15:0]         byte_cnt_q;
  logic                frame_err_q;
  logic                overrun_q;

  // Bit counter: parked at zero outside a frame and cleared on abort or byte completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
    end else if ((state_q == IDLE) || ss_rise || byte_done) begin
      bitcnt <= '0;
    end else if (shift_en) begin
      bitcnt <= bitcnt + BIT_CNT_W'(1);
    end
  end

  // Shift register and completed-byte capture, MSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      byte_hold <= '0;
    end else begin
      if (shift_en) begin
        shreg <= {shreg[SPI_BITS-3:0], mosi_s};
      end
      if (byte_done) begin
        byte_hold <= {shreg, mosi_s};
      end
    end
  end

  // Nibbles still to unpack from byte_hold: 2 = upper next, 1 = lower next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 2'd0;
    end else if (byte_done) begin
      pend <= 2'd2;
    end else if (pend != 2'd0) begin
      pend <= pend - 2'd1;
    end
  end

  // ------------------------------------------------------------------- FIFO
  logic    fifo_push;
  nibble_t fifo_push_dat;
  logic    fifo_pop;
  logic    fifo_full;
  logic    fifo_empty;
  logic    nib_drop;
  logic    byte_overlap;

  assign fifo_push     = (pend != 2'd0);
  assign fifo_push_dat = pick_nibble(byte_hold, pend == 2'd2);
  assign fifo_pop      = SAMPLE_VALID && SAMPLE_READY;
  assign nib_drop      = fifo_push && fifo_full && !fifo_pop;
  assign byte_overlap  = byte_done && (pend != 2'd0);

  sample_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (fifo_push_dat),
    .pop      (fifo_pop),
    .head_dat (SAMPLE_OUT),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign SAMPLE_VALID = !fifo_empty;

  // ------------------------------------------------------- counter and flags
  // Byte counter wraps naturally; error flags are sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (byte_done) begin
        byte_cnt_q <= byte_cnt_q + 16'd1;
      end
      if (frame_abort) begin
        frame_err_q <= 1'b1;
      end
      if (nib_drop || byte_overlap) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign BYTE_COUNT = byte_cnt_q;
  assign FRAME_ERR  = frame_err_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_spi_sample_rx.sv
// Directed bench for spi_sample_rx: single byte with latency, burst, backpressure, frame error, reset mid-byte, counter wrap.
// Latency: n/a.
// Backpressure: SAMPLE_READY is driven per step; every accepted sample is logged by a monitor.
module tb_spi_sample_rx;

  logic        clk;
  logic        rst_n;
  logic        sck;
  logic        ss;
  logic        mosi;
  logic [3:0]  sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] byte_count;
  logic        frame_err;
  logic        overrun;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] got[$];

  spi_sample_rx #(
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .MCU_CLK_25_000 (clk),
    .RESET_N        (rst_n),
    .MCU_SCK        (sck),
    .MCU_SS         (ss),
    .MCU_MOSI       (mosi),
    .SAMPLE_OUT     (sample_out),
    .SAMPLE_VALID   (sample_valid),
    .SAMPLE_READY   (sample_ready),
    .BYTE_COUNT     (byte_count),
    .FRAME_ERR      (frame_err),
    .OVERRUN        (overrun)
  );

  // 25 MHz clock
  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Log every accepted sample; sampled mid-cycle after the inputs settle
  initial begin
    forever begin
      @(negedge clk);
      #5;
      if (sample_valid && sample_ready) got.push_back(sample_out);
    end
  end

  // Run-away guard
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sck = 1'b0; ss = 1'b1; mosi = 1'b0; sample_ready = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
  endtask

  // MSB first, 8 clocks per SCK period (3.125 MHz)
  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      sck = 1'b0; mosi = b[i];
      tick(4);
      sck = 1'b1;
      tick(4);
    end
  endtask

  task automatic ss_low();
    ss = 1'b0;
    tick(4);
  endtask

  task automatic ss_high();
    sck = 1'b0;
    tick(4);
    ss = 1'b1;
    tick(6);
  endtask

  task automatic frame_byte(input logic [7:0] b);
    ss_low();
    send_bits(b, 8);
    ss_high();
  endtask

  task automatic chk_q2(input string tag, input logic [3:0] a, input logic [3:0] b);
    chk({tag, "_len"}, got.size(), 2);
    if (got.size() >= 2) begin
      chk({tag, "_s0"}, got[0], a);
      chk({tag, "_s1"}, got[1], b);
    end
  endtask

  logic [3:0] exp_n;
  bit         seen;

  initial begin
    rst_n = 1'b0; sck = 1'b0; ss = 1'b1; mosi = 1'b0; sample_ready = 1'b0;
    tick(2);
    // reset state while RESET_N is low
    chk("rst_out",   sample_out,   4'h0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_cnt",   byte_count,   16'h0000);
    chk("rst_ferr",  frame_err,    1'b0);
    chk("rst_ovr",   overrun,      1'b0);
    do_reset();

    // ---- single byte 0xA5 with latency checks, READY low
    ss_low();
    send_bits(8'hA5, 7);
    sck = 1'b0; mosi = 1'b1;
    tick(4);
    sck = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(1);
      if (byte_count == 16'd1) seen = 1'b1;
    end
    chk("single_cnt_seen", seen, 1'b1);
    chk("single_valid_e1", sample_valid, 1'b0);
    tick(1);
    chk("single_valid_e2", sample_valid, 1'b1);
    chk("single_out_e2",   sample_out,   4'hA);
    tick(1);
    chk("single_hold",     sample_out,   4'hA);
    sample_ready = 1'b1;
    tick(1);
    chk("single_out_lo",   sample_out,   4'h5);
    tick(1);
    chk("single_empty",    sample_valid, 1'b0);
    sample_ready = 1'b0;
    ss_high();
    chk("single_cnt",  byte_count, 16'd1);
    chk("single_ferr", frame_err,  1'b0);
    chk("single_ovr",  overrun,    1'b0);

    // ---- burst of 16 bytes in one frame, READY high
    do_reset();
    got.delete();
    sample_ready = 1'b1;
    ss_low();
    for (int b = 0; b < 16; b++) send_bits(8'(b), 8);
    ss_high();
    chk("burst_len", got.size(), 32);
    for (int i = 0; i < 32; i++) begin
      exp_n = (i % 2 == 0) ? 4'h0 : 4'(i / 2);
      if (i < got.size()) chk($sformatf("burst_s%0d", i), got[i], exp_n);
    end
    chk("burst_cnt", byte_count, 16'd16);
    chk("burst_ovr", overrun,    1'b0);

    // ---- backpressure: 3 bytes into a depth-4 FIFO
    do_reset();
    got.delete();
    ss_low();
    send_bits(8'h12, 8);
    send_bits(8'h34, 8);
    send_bits(8'h56, 8);
    ss_high();
    chk("bp_ovr",   overrun,      1'b1);
    chk("bp_valid", sample_valid, 1'b1);
    chk("bp_head",  sample_out,   4'h1);
    chk("bp_cnt",   byte_count,   16'd3);
    sample_ready = 1'b1;
    tick(8);
    sample_ready = 1'b0;
    chk("bp_len", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk($sformatf("bp_s%0d", i), got[i], 4'(i + 1));
    end
    chk("bp_empty", sample_valid, 1'b0);

    // ---- frame error: 5 bits then SS high
    do_reset();
    got.delete();
    sample_ready = 1'b1;
    ss_low();
    send_bits(8'hFF, 5);
    ss_high();
    chk("ferr_flag",  frame_err,  1'b1);
    chk("ferr_cnt",   byte_count, 16'd0);
    chk("ferr_nosmp", got.size(), 0);
    frame_byte(8'h3C);
    chk_q2("ferr_next", 4'h3, 4'hC);
    chk("ferr_cnt2",   byte_count, 16'd1);
    chk("ferr_sticky", frame_err,  1'b1);

    // ---- reset mid-byte, SS still low at release
    got.delete();
    ss_low();
    send_bits(8'h81, 4);
    rst_n = 1'b0;
    tick(1);
    chk("mid_out",   sample_out,   4'h0);
    chk("mid_valid", sample_valid, 1'b0);
    chk("mid_cnt",   byte_count,   16'd0);
    chk("mid_ferr",  frame_err,    1'b0);
    chk("mid_ovr",   overrun,      1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    send_bits(8'hFF, 8);
    sck = 1'b0;
    tick(4);
    chk("mid_ignored_cnt", byte_count, 16'd0);
    chk("mid_ignored_smp", got.size(), 0);
    ss = 1'b1;
    tick(6);
    frame_byte(8'h81);
    chk_q2("mid_byte", 4'h8, 4'h1);
    chk("mid_cnt1", byte_count, 16'd1);
    chk("mid_ferr1", frame_err, 1'b0);

    // ---- counter wrap
    do_reset();
    got.delete();
    sample_ready = 1'b1;
    force dut.byte_cnt_q = 16'hFFFF;
    tick(1);
    release dut.byte_cnt_q;
    tick(1);
    chk("wrap_pre", byte_count, 16'hFFFF);
    frame_byte(8'h7E);
    chk("wrap_cnt", byte_count, 16'h0000);
    chk_q2("wrap_byte", 4'h7, 4'hE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
